i2c_gpio_expander: RTL and testbench
====================================

I2C_GPIO_EXPANDER -- requirements
Module: i2c_gpio_expander

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of 8-bit IO ports; legal range 1..8.
REQ-002 Parameter ADDR_BASE, default 7'b1110100, 7-bit device address with the low ADDR_SEL_W bits zero.
REQ-003 Parameter ADDR_SEL_W, default 2, width of the address-select input; legal range 0..3.
REQ-004 clk  in  1  system clock; SHALL be at least 8x faster than SCL.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 scl  in  1  I2C clock, asynchronous to clk.
REQ-007 sda_i  in  1  I2C data in, asynchronous to clk.
REQ-008 sda_o  out  1  constant 0 (open-drain model).
REQ-009 sda_o_en  out  1  1 = pull SDA low.
REQ-010 addr_sel  in  ADDR_SEL_W  device address = ADDR_BASE | addr_sel.
REQ-011 io_port_i  in  8*NUM_PORTS  pin input levels; byte p = port p.
REQ-012 io_port_o  out  8*NUM_PORTS  output-port register contents.
REQ-013 io_port_o_en  out  8*NUM_PORTS  ~config; 1 = pin driven.
REQ-014 int_n  out  1  active-low interrupt.

Function
REQ-015 scl and sda_i SHALL pass through 2-flop synchronizers; edge, START and STOP detection SHALL use the synchronized values only.
REQ-016 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both SHALL be recognised in any state.
REQ-017 8-bit command pointer = {bank[1:0], port[2:0]}:
- bank 0 input (RO)
- bank 1 output
- bank 2 polarity
- bank 3 config
REQ-018 Input byte p SHALL read as io_port_i[p] ^ polarity[p], sampled on the clk cycle the byte loads into the read shifter.
REQ-019 Ports with index >= NUM_PORTS SHALL read 0x00 and ignore writes, but SHALL still be ACKed; writes to bank 0 SHALL be ACKed and ignored.
REQ-020 FSM states: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-021 Transitions:
- START -> ADDR; STOP -> IDLE.
- ADDR shifts 8 bits MSB-first on SCL rising.
- Address match -> ADDR_ACK; mismatch -> IDLE, no ACK.
- R/W=0 -> CMD; R/W=1 -> RDATA, using the current pointer.
REQ-022 Write path: CMD -> CMD_ACK (pointer loaded) -> WDATA.
- Each WDATA byte is ACKed in WDATA_ACK and written on the ACK-bit SCL falling edge.
- Pointer then auto-increments.
REQ-023 Read path: RDATA drives the MSB after the ACK falling edge; RDATA_ACK samples master ACK on SCL rising.
- ACK -> pointer increments -> RDATA.
- NACK -> IDLE (wait for STOP/START).
REQ-024 Auto-increment SHALL wrap port from NUM_PORTS-1 to 0 within the same bank; the bank never changes.
REQ-025 Repeated START SHALL keep the pointer; a write frame ending after CMD_ACK sets the pointer only.
REQ-026 sda_o_en SHALL change only within 2 clk cycles after a synchronized SCL falling edge, never while synchronized SCL is high.
REQ-027 Per port, the block SHALL hold a snapshot updated whenever input byte p is loaded for read.
REQ-028 int_n SHALL be 0 while any bit with config=1 has io_port_i differing from its snapshot (pre-polarity), otherwise 1; registered, 1 clk latency after synchronization.
REQ-029 io_port_o SHALL take a new value the clk cycle after the write event; no polarity is applied to outputs.

Reset
REQ-030 On rst assertion, asynchronously:
- FSM to IDLE; sda_o_en=0; pointer=0x00.
- output=0xFF, polarity=0x00, config=0xFF per port.
- int_n=1; snapshots = io_port_i sampled on the first clk after rst deasserts.
REQ-031 rst mid-transfer SHALL abort the transfer; the bus SHALL be released on the same cycle.

Verification
REQ-032 Write 0xEA,0x08,0x55,0xAA then STOP (addr_sel=2'b01) -> all bytes ACKed; io_port_o=0xAA55.
REQ-033 Write config 0xEA,0x18,0x00 -> io_port_o_en[7:0]=0xFF; repeat with 0x1A at NUM_PORTS=2 -> ACKed, no change.
REQ-034 polarity[0]=0x0F, io_port_i[7:0]=0x33; write 0xEA,0x00; repeated START 0xEB; read 3 bytes, NACK last -> 0x3C, port1, 0x3C (wrap).
REQ-035 Address 0x74 while addr_sel=2'b01 -> no ACK; state returns to IDLE; registers unchanged.
REQ-036 Toggle io_port_i[3] (config=1) -> int_n=0 within 4 clk; read input port 0 -> int_n=1; toggle bit with config=0 -> int_n stays 1.
REQ-037 Assert rst during a read data bit -> sda_o_en=0 immediately; registers at reset values; next valid frame completes normally.

Source files
------------

// File: rtl/i2c_gpio_expander.sv
// i2c_gpio_expander: I2C slave exposing NUM_PORTS 8-bit GPIO ports through four register banks
// addressed by an 8-bit command pointer {bank[1:0], port[2:0]}:
//   bank 0 input (read-only, polarity applied), bank 1 output, bank 2 polarity, bank 3 config.
// Ports:
//   clk, rst          system clock (>= 8x SCL), asynchronous active-high reset
//   scl, sda_i        I2C bus inputs, asynchronous to clk
//   sda_o, sda_o_en   open-drain SDA drive (sda_o is always 0, sda_o_en=1 pulls low)
//   addr_sel          low address bits, device address = ADDR_BASE | addr_sel
//   io_port_i         pin levels, byte p = port p
//   io_port_o         output register contents
//   io_port_o_en      pin drive enables (inverse of config)
//   int_n             active-low input-change interrupt
module i2c_gpio_expander #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter logic [6:0]  ADDR_BASE  = 7'b1110100,
  parameter int unsigned ADDR_SEL_W = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          scl,
  input  logic                                          sda_i,
  output logic                                          sda_o,
  output logic                                          sda_o_en,
  input  logic [(ADDR_SEL_W > 0 ? ADDR_SEL_W : 1)-1:0]  addr_sel,
  input  logic [8*NUM_PORTS-1:0]                        io_port_i,
  output logic [8*NUM_PORTS-1:0]                        io_port_o,
  output logic [8*NUM_PORTS-1:0]                        io_port_o_en,
  output logic                                          int_n
);

  localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);
  // Masks off the unused addr_sel bit when ADDR_SEL_W is 0.
  localparam logic [6:0] SEL_MASK  = 7'((32'd1 << ADDR_SEL_W) - 32'd1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t     state;
  logic       scl_m, scl_s, scl_p, sda_m, sda_s, sda_p;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [8*NUM_PORTS-1:0] io_m, io_s;
  logic [7:0] out_reg  [NUM_PORTS];
  logic [7:0] pol_reg  [NUM_PORTS];
  logic [7:0] cfg_reg  [NUM_PORTS];
  logic [7:0] snap     [NUM_PORTS];
  logic [7:0] shreg, tx, ptr, ptr_inc, rd_byte;
  logic [4:0] ld_ptr;
  logic [3:0] bit_cnt;
  logic [6:0] dev_addr;
  logic       rw, mack, snap_init, irq, load_rd;

  assign sda_o = 1'b0;

  // Bus synchronizers; the third stage (_p) is the previous synchronized value for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {scl_m, scl_s, scl_p, sda_m, sda_s, sda_p} <= 6'b111111;
    end else begin
      {scl_m, scl_s, scl_p} <= {scl, scl_m, scl_s};
      {sda_m, sda_s, sda_p} <= {sda_i, sda_m, sda_s};
    end
  end

  // Pin synchronizer for the interrupt comparator; fills while clk runs during reset.
  always_ff @(posedge clk) begin
    io_m <= io_port_i;
    io_s <= io_m;
  end

  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
  assign dev_addr  = ADDR_BASE | (7'(addr_sel) & SEL_MASK);
  assign load_rd   = (state == ADDR_ACK && rw) || (state == RDATA_ACK && mack);

  always_comb begin
    ptr_inc      = ptr;
    ptr_inc[2:0] = (ptr[2:0] >= LAST_PORT) ? 3'd0 : ptr[2:0] + 3'd1;
    // After a master ACK the next byte comes from the incremented pointer.
    ld_ptr       = (state == RDATA_ACK) ? ptr_inc[4:0] : ptr[4:0];
    rd_byte      = 8'h00;
    irq          = 1'b0;
    io_port_o    = '0;
    io_port_o_en = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (ld_ptr[2:0] == 3'(p)) begin
        case (ld_ptr[4:3])
          2'd0:    rd_byte = io_port_i[8*p +: 8] ^ pol_reg[p];
          2'd1:    rd_byte = out_reg[p];
          2'd2:    rd_byte = pol_reg[p];
          default: rd_byte = cfg_reg[p];
        endcase
      end
      irq = irq | (|((io_s[8*p +: 8] ^ snap[p]) & cfg_reg[p]));
      io_port_o[8*p +: 8]    = out_reg[p];
      io_port_o_en[8*p +: 8] = ~cfg_reg[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sda_o_en  <= 1'b0;
      ptr       <= 8'h00;
      shreg     <= 8'h00;
      tx        <= 8'h00;
      bit_cnt   <= 4'd0;
      rw        <= 1'b0;
      mack      <= 1'b0;
      snap_init <= 1'b1;
      int_n     <= 1'b1;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        out_reg[p] <= 8'hFF;
        pol_reg[p] <= 8'h00;
        cfg_reg[p] <= 8'hFF;
        snap[p]    <= 8'h00;
      end
    end else begin
      if (snap_init) begin
        for (int p = 0; p < int'(NUM_PORTS); p++) snap[p] <= io_port_i[8*p +: 8];
      end
      snap_init <= 1'b0;
      int_n     <= snap_init | ~irq;

      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        sda_o_en <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        sda_o_en <= 1'b0;
      end else begin
        if (scl_rise) begin
          shreg   <= {shreg[6:0], sda_s};
          bit_cnt <= bit_cnt + 4'd1;
          if (state == RDATA_ACK) mack <= ~sda_s;
        end
        // All SDA drive changes happen here, just after SCL has gone low.
        if (scl_fall) begin
          case (state)
            ADDR: begin
              if (bit_cnt == 4'd8) begin
                if (shreg[7:1] == dev_addr) begin
                  state    <= ADDR_ACK;
                  rw       <= shreg[0];
                  sda_o_en <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end
            ADDR_ACK: begin
              sda_o_en <= 1'b0;
              bit_cnt  <= 4'd0;
              state    <= rw ? RDATA : CMD;
            end
            CMD: begin
              if (bit_cnt == 4'd8) begin
                ptr      <= shreg;
                state    <= CMD_ACK;
                sda_o_en <= 1'b1;
              end
            end
            CMD_ACK: begin
              sda_o_en <= 1'b0;
              bit_cnt  <= 4'd0;
              state    <= WDATA;
            end
            WDATA: begin
              if (bit_cnt == 4'd8) begin
                tx       <= shreg;  // shreg keeps shifting during the ACK bit
                state    <= WDATA_ACK;
                sda_o_en <= 1'b1;
              end
            end
            WDATA_ACK: begin
              sda_o_en <= 1'b0;
              bit_cnt  <= 4'd0;
              state    <= WDATA;
              ptr      <= ptr_inc;
              for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (ptr[2:0] == 3'(p)) begin
                  case (ptr[4:3])
                    2'd1:    out_reg[p] <= tx;
                    2'd2:    pol_reg[p] <= tx;
                    2'd3:    cfg_reg[p] <= tx;
                    default: ;
                  endcase
                end
              end
            end
            RDATA: begin
              if (bit_cnt == 4'd8) begin
                sda_o_en <= 1'b0;
                state    <= RDATA_ACK;
              end else begin
                tx       <= {tx[6:0], tx[7]};
                sda_o_en <= ~tx[6];
              end
            end
            RDATA_ACK: begin
              sda_o_en <= 1'b0;
              if (mack) begin
                ptr     <= ptr_inc;
                bit_cnt <= 4'd0;
                state   <= RDATA;
              end else begin
                state <= IDLE;
              end
            end
            default: ;
          endcase
          // Loading a byte for transmit overrides the release above and drives its MSB.
          if (load_rd) begin
            tx       <= rd_byte;
            sda_o_en <= ~rd_byte[7];
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
              if (ld_ptr[4:3] == 2'd0 && ld_ptr[2:0] == 3'(p)) snap[p] <= io_port_i[8*p +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_gpio_expander.sv
// Directed bench for i2c_gpio_expander: bit-banged I2C master with an open-drain SDA model,
// hand-computed expected register, read-back, ACK and interrupt values.
module tb_i2c_gpio_expander;

  localparam int Q = 50;  // quarter SCL period, 5 clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line, sda_o, sda_o_en, int_n;
  logic [1:0]  addr_sel = 2'b01;
  logic [15:0] io_in = 16'hA533;
  logic [15:0] io_out, io_en;
  int          n_vec = 0;
  int          n_err = 0;

  assign sda_line = sda_m & ~sda_o_en;

  always #5 clk = ~clk;

  i2c_gpio_expander #(
    .NUM_PORTS (2),
    .ADDR_BASE (7'b1110100),
    .ADDR_SEL_W(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scl         (scl),
    .sda_i       (sda_line),
    .sda_o       (sda_o),
    .sda_o_en    (sda_o_en),
    .addr_sel    (addr_sel),
    .io_port_i   (io_in),
    .io_port_o   (io_out),
    .io_port_o_en(io_en),
    .int_n       (int_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    scl   = 1'b1;
    sda_m = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Works from idle and as a repeated START with SCL low.
  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic wb(input logic [7:0] b, input logic exp_ack, input string tag);
    logic ack;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q;
      scl   = 1'b1; #(2*Q);
      scl   = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    ack   = ~sda_line; #Q;
    scl   = 1'b0; #Q;
    check_eq(tag, ack, exp_ack);
  endtask

  task automatic rb(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q;
      scl   = 1'b1; #Q;
      d[i]  = sda_line; #Q;
      scl   = 1'b0; #Q;
    end
    sda_m = nack; #Q;
    scl   = 1'b1; #(2*Q);
    scl   = 1'b0; #Q;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    do_reset();
    check_eq("rst_sda_en", sda_o_en, 1'b0);
    check_eq("rst_sda_o", sda_o, 1'b0);
    check_eq("rst_out", io_out, 16'hFFFF);
    check_eq("rst_oen", io_en, 16'h0000);
    check_eq("rst_int", int_n, 1'b1);

    // Output write with auto-increment across both ports
    i2c_start();
    wb(8'hEA, 1'b1, "w_addr");
    wb(8'h08, 1'b1, "w_cmd");
    wb(8'h55, 1'b1, "w_d0");
    wb(8'hAA, 1'b1, "w_d1");
    i2c_stop();
    check_eq("out_aa55", io_out, 16'hAA55);

    // Config port 0 to all outputs, then an out-of-range port
    i2c_start();
    wb(8'hEA, 1'b1, "c_addr");
    wb(8'h18, 1'b1, "c_cmd");
    wb(8'h00, 1'b1, "c_d0");
    i2c_stop();
    check_eq("cfg_p0_en", io_en, 16'h00FF);
    i2c_start();
    wb(8'hEA, 1'b1, "oob_addr");
    wb(8'h1A, 1'b1, "oob_cmd");
    wb(8'h00, 1'b1, "oob_d0");
    i2c_stop();
    check_eq("oob_en", io_en, 16'h00FF);
    check_eq("oob_out", io_out, 16'hAA55);

    // Address with the wrong select bits is ignored
    i2c_start();
    wb(8'hE8, 1'b0, "bad_addr");
    check_eq("bad_release", sda_o_en, 1'b0);
    wb(8'h08, 1'b0, "bad_cmd");
    wb(8'h00, 1'b0, "bad_d0");
    i2c_stop();
    check_eq("bad_out", io_out, 16'hAA55);
    check_eq("bad_en", io_en, 16'h00FF);

    // Polarity on port 0, then a 3-byte read wrapping back to port 0
    i2c_start();
    wb(8'hEA, 1'b1, "p_addr");
    wb(8'h10, 1'b1, "p_cmd");
    wb(8'h0F, 1'b1, "p_d0");
    i2c_stop();
    i2c_start();
    wb(8'hEA, 1'b1, "r_waddr");
    wb(8'h00, 1'b1, "r_cmd");
    i2c_start();
    wb(8'hEB, 1'b1, "r_raddr");
    rb(d, 1'b0);
    check_eq("rd_p0", d, 8'h3C);
    rb(d, 1'b0);
    check_eq("rd_p1", d, 8'hA5);
    rb(d, 1'b1);
    check_eq("rd_wrap", d, 8'h3C);
    i2c_stop();

    // Interrupt: set by a config=1 input change, cleared by reading, masked by config=0
    do_reset();
    check_eq("rst2_out", io_out, 16'hFFFF);
    check_eq("rst2_en", io_en, 16'h0000);
    io_in[3] = ~io_in[3];  // port 0 = 0x3B
    repeat (4) @(negedge clk);
    check_eq("int_set", int_n, 1'b0);
    i2c_start();
    wb(8'hEA, 1'b1, "i_waddr");
    wb(8'h00, 1'b1, "i_cmd");
    i2c_start();
    wb(8'hEB, 1'b1, "i_raddr");
    rb(d, 1'b1);
    i2c_stop();
    check_eq("int_rd", d, 8'h3B);
    repeat (4) @(negedge clk);
    check_eq("int_clr", int_n, 1'b1);
    i2c_start();
    wb(8'hEA, 1'b1, "ic_addr");
    wb(8'h18, 1'b1, "ic_cmd");
    wb(8'hFE, 1'b1, "ic_d0");
    i2c_stop();
    check_eq("int_cfg_en", io_en, 16'h0001);
    io_in[0] = ~io_in[0];  // port 0 = 0x3A, bit 0 is an output
    repeat (6) @(negedge clk);
    check_eq("int_masked", int_n, 1'b1);
    io_in[1] = ~io_in[1];  // port 0 = 0x38
    repeat (4) @(negedge clk);
    check_eq("int_bit1", int_n, 1'b0);

    // Reset while the slave drives bit 7 (0) of 0x38
    i2c_start();
    wb(8'hEA, 1'b1, "a_waddr");
    wb(8'h00, 1'b1, "a_cmd");
    i2c_start();
    wb(8'hEB, 1'b1, "a_raddr");
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    check_eq("abort_drive", sda_o_en, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("abort_release", sda_o_en, 1'b0);
    check_eq("abort_out", io_out, 16'hFFFF);
    check_eq("abort_en", io_en, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Normal traffic after the aborted transfer
    i2c_start();
    wb(8'hEA, 1'b1, "post_addr");
    wb(8'h08, 1'b1, "post_cmd");
    wb(8'h12, 1'b1, "post_d0");
    i2c_stop();
    check_eq("post_out", io_out, 16'hFF12);
    i2c_start();
    wb(8'hEA, 1'b1, "post_waddr");
    wb(8'h08, 1'b1, "post_rcmd");
    i2c_start();
    wb(8'hEB, 1'b1, "post_raddr");
    rb(d, 1'b1);
    i2c_stop();
    check_eq("post_rd", d, 8'h12);
    check_eq("post_int", int_n, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
